// File: rtl/program_mem_controller_pkg.sv
// Shared types for the program memory controller.
// Holds the controller state encoding and a helper for pointer widths.
// No ports; imported by the controller, its arbiter and the bench.
package program_mem_controller_pkg;

    // Controller phases: waiting for work, memory access in flight,
    // one-cycle completion pulse toward the granted consumer.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        READ_WAITING = 2'b01,
        RELAYING     = 2'b10
    } ctrl_state_e;

    // Width of an index into n ports; never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/program_mem_controller_if.sv
// Bundle of the fetcher-side and memory-side read handshakes.
// master: controller view (drives consumer responses and memory requests).
// slave: environment view (fetchers plus external program memory).
interface program_mem_controller_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic                                    mem_read_valid;
    logic [ADDR_BITS-1:0]                    mem_read_address;
    logic                                    mem_read_ready;
    logic [DATA_BITS-1:0]                    mem_read_data;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        input  mem_read_ready, mem_read_data,
        output consumer_read_ready, consumer_read_data,
        output mem_read_valid, mem_read_address
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        output mem_read_ready, mem_read_data,
        input  consumer_read_ready, consumer_read_data,
        input  mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/program_mem_controller_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_ptr_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; an empty request vector yields an all-zero grant.
// Ports: req_i request vector, last_ptr_i index of previous winner, gnt_o one-hot grant.
module rr_arbiter
    import program_mem_controller_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the ring starting just past the previous winner; the previous
    // winner itself is visited last so it cannot starve the others.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(last_ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_mem_controller.sv
// Arbitrates instruction fetches from several consumers onto one program memory port.
// Latency: 3 cycles minimum (grant, memory answer, one-cycle ready pulse); one access outstanding.
// Backpressure: holds mem_read_valid/address until mem_read_ready; unserved requests simply wait.
// Ports: clk, reset_n (async active-low), bus (master modport of program_mem_controller_if),
// and read_count (completion counter) only when PROGRAM_MEM_CTRL_PERF_EN is defined.
module program_mem_controller
    import program_mem_controller_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    program_mem_controller_if.master      bus
`ifdef PROGRAM_MEM_CTRL_PERF_EN
    ,
    output logic [31:0]                   read_count
`endif
);

    localparam int                IDX_W    = idx_bits(NUM_CONSUMERS);
    // Reset the pointer to the last port so consumer 0 wins the first grant.
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CONSUMERS - 1);

    ctrl_state_e                             state_q, state_d;
    logic [IDX_W-1:0]                        last_granted_q, last_granted_d;
    logic [IDX_W-1:0]                        granted_q, granted_d;
    logic                                    mem_vld_q, mem_vld_d;
    logic [ADDR_BITS-1:0]                    mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]                cons_rdy_q, cons_rdy_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_dat_q, cons_dat_d;

    logic [NUM_CONSUMERS-1:0]                eligible;
    logic [NUM_CONSUMERS-1:0]                gnt;
    logic [IDX_W-1:0]                        gnt_idx;
    logic                                    complete;

    // A consumer being handed its data this cycle must not be re-granted on the same request.
    assign eligible = bus.consumer_read_valid & ~cons_rdy_q;
    assign complete = (state_q == READ_WAITING) && bus.mem_read_ready;

    rr_arbiter #(
        .NUM_REQ    (NUM_CONSUMERS)
    ) u_arb (
        .req_i      (eligible),
        .last_ptr_i (last_granted_q),
        .gnt_o      (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_granted_d = last_granted_q;
        granted_d      = granted_q;
        mem_vld_d      = mem_vld_q;
        mem_addr_d     = mem_addr_q;
        cons_rdy_d     = cons_rdy_q;
        cons_dat_d     = cons_dat_q;

        case (state_q)
            IDLE: begin
                // Also drops any stray memory strobe arriving while idle.
                if (|gnt) begin
                    granted_d  = gnt_idx;
                    mem_vld_d  = 1'b1;
                    mem_addr_d = bus.consumer_read_address[gnt_idx];
                    state_d    = READ_WAITING;
                end
            end
            READ_WAITING: begin
                if (complete) begin
                    mem_vld_d             = 1'b0;
                    cons_dat_d[granted_q] = bus.mem_read_data;
                    cons_rdy_d            = '0;
                    cons_rdy_d[granted_q] = 1'b1;
                    state_d               = RELAYING;
                end
            end
            RELAYING: begin
                cons_rdy_d     = '0;
                last_granted_d = granted_q;
                state_d        = IDLE;
            end
            default: begin
                state_d    = IDLE;
                mem_vld_d  = 1'b0;
                cons_rdy_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_granted_q <= LAST_RST;
            granted_q      <= '0;
            mem_vld_q      <= 1'b0;
            mem_addr_q     <= '0;
            cons_rdy_q     <= '0;
            cons_dat_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_granted_q <= last_granted_d;
            granted_q      <= granted_d;
            mem_vld_q      <= mem_vld_d;
            mem_addr_q     <= mem_addr_d;
            cons_rdy_q     <= cons_rdy_d;
            cons_dat_q     <= cons_dat_d;
        end
    end

    assign bus.mem_read_valid      = mem_vld_q;
    assign bus.mem_read_address    = mem_addr_q;
    assign bus.consumer_read_ready = cons_rdy_q;
    assign bus.consumer_read_data  = cons_dat_q;

`ifdef PROGRAM_MEM_CTRL_PERF_EN
    logic [31:0] read_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_count_q <= '0;
        end else if (complete) begin
            read_count_q <= read_count_q + 32'd1;
        end
    end

    assign read_count = read_count_q;
`endif

endmodule

// File: tb/tb_program_mem_controller.sv
module tb_program_mem_controller;
    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    program_mem_controller_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) bus ();
`ifdef PROGRAM_MEM_CTRL_PERF_EN
    logic [31:0] read_count;
`endif

    program_mem_controller #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .NUM_CONSUMERS (NC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef PROGRAM_MEM_CTRL_PERF_EN
        ,
        .read_count (read_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what each consumer should currently hold, who was served last,
    // and how many completions happened since reset.
    logic [DB-1:0] exp_data [NC];
    int            last_served;
    int            completions;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next consumer in round-robin order after 'last' that is requesting; -1 if none.
    function automatic int rr_pick(input logic [NC-1:0] v, input int last);
        for (int k = 1; k <= NC; k++) begin
            if (v[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NC; j++) exp_data[j] = '0;
        last_served = NC - 1;
        completions = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mvld"}, 64'(bus.mem_read_valid), 64'd0);
        check({tag, "_maddr"}, 64'(bus.mem_read_address), 64'd0);
        check({tag, "_rdy"}, 64'(bus.consumer_read_ready), 64'd0);
        for (int j = 0; j < NC; j++) check({tag, "_dat"}, 64'(bus.consumer_read_data[j]), 64'd0);
`ifdef PROGRAM_MEM_CTRL_PERF_EN
        check({tag, "_cnt"}, 64'(read_count), 64'd0);
`endif
    endtask

    // One full transaction, entered from IDLE with the request inputs already driven.
    task automatic run_txn(input int stall, input logic [DB-1:0] rdata, input bit bump,
                           input bit scramble, output int got, output logic [AB-1:0] issued);
        int            e;
        logic [1:0]    ei;
        logic [AB-1:0] exp_addr;
        logic [NC-1:0] ev;
        e        = rr_pick(bus.consumer_read_valid, last_served);
        if (e < 0) e = 0;
        ei       = 2'(e);
        exp_addr = bus.consumer_read_address[ei];
        tick();
        issued = bus.mem_read_address;
        check("grant_vld", 64'(bus.mem_read_valid), 64'd1);
        check("grant_addr", 64'(bus.mem_read_address), 64'(exp_addr));
        check("wait_rdy", 64'(bus.consumer_read_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            if (scramble) begin
                bus.consumer_read_valid = NC'($urandom);
                for (int j = 0; j < NC; j++) bus.consumer_read_address[j] = AB'($urandom);
            end
            bus.mem_read_data = DB'($urandom);
            tick();
            check("stall_vld", 64'(bus.mem_read_valid), 64'd1);
            check("stall_addr", 64'(bus.mem_read_address), 64'(exp_addr));
            check("stall_rdy", 64'(bus.consumer_read_ready), 64'd0);
        end
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = rdata;
        tick();
        got = -1;
        for (int j = 0; j < NC; j++) if (bus.consumer_read_ready[j]) got = (got == -1) ? j : -2;
        ev     = '0;
        ev[ei] = 1'b1;
        check("done_rdy", 64'(bus.consumer_read_ready), 64'(ev));
        check("done_vld", 64'(bus.mem_read_valid), 64'd0);
        exp_data[e] = rdata;
        last_served = e;
        completions++;
        for (int j = 0; j < NC; j++) check("done_dat", 64'(bus.consumer_read_data[j]), 64'(exp_data[j]));
`ifdef PROGRAM_MEM_CTRL_PERF_EN
        check("done_cnt", 64'(read_count), 64'(completions));
`endif
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data  = DB'($urandom);
        if (bump) bus.consumer_read_address[ei] = exp_addr + AB'(4);
        tick();
        check("relay_rdy", 64'(bus.consumer_read_ready), 64'd0);
        check("relay_vld", 64'(bus.mem_read_valid), 64'd0);
        check("relay_dat", 64'(bus.consumer_read_data[ei]), 64'(rdata));
    endtask

    initial begin
        int            got;
        int            order [5];
        logic [AB-1:0] issued;
        logic [NC-1:0] v;

        order = '{0, 1, 2, 3, 0};
        bus.consumer_read_valid   = '0;
        bus.consumer_read_address = '0;
        bus.mem_read_ready        = 1'b0;
        bus.mem_read_data         = '0;
        model_reset();

        // Asynchronous reset: outputs must clear before any clock edge.
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        tick();
        tick();
        check_reset_outputs("rst_held");
        reset_n = 1'b1;
        tick();
        check("idle_after_rst", 64'(bus.mem_read_valid), 64'd0);

        // Four continuous requesters: strict 0,1,2,3,0 rotation.
        bus.consumer_read_valid = 4'b1111;
        for (int j = 0; j < NC; j++) bus.consumer_read_address[j] = AB'(8'h20 + j);
        for (int i = 0; i < 5; i++) begin
            run_txn(0, DB'($urandom), 1'b0, 1'b0, got, issued);
            check("rr_order", 64'(got), 64'(order[i]));
        end

        // Single request from consumer 0 at 0x10, memory answers with 0xABCD next cycle.
        bus.consumer_read_valid    = 4'b0001;
        bus.consumer_read_address[0] = 8'h10;
        run_txn(0, 16'hABCD, 1'b0, 1'b0, got, issued);
        check("single_gnt", 64'(got), 64'd0);
        check("single_addr", 64'(issued), 64'h10);
        check("single_dat", 64'(bus.consumer_read_data[0]), 64'hABCD);
        bus.consumer_read_valid = '0;
        // No requests: stay idle, and a stray memory strobe changes nothing.
        bus.mem_read_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_mvld", 64'(bus.mem_read_valid), 64'd0);
            check("idle_rdy", 64'(bus.consumer_read_ready), 64'd0);
        end
        bus.mem_read_ready = 1'b0;

        // Ten-cycle memory stall with other inputs churning underneath.
        bus.consumer_read_valid      = 4'b0010;
        bus.consumer_read_address[1] = 8'h77;
        run_txn(10, 16'h1234, 1'b0, 1'b1, got, issued);
        check("stall_gnt", 64'(got), 64'd1);

        // Consumer 2 moves to a new address on its ready edge and keeps valid high.
        bus.consumer_read_valid      = 4'b0100;
        bus.consumer_read_address[2] = 8'h40;
        run_txn(0, 16'h0F0F, 1'b1, 1'b0, got, issued);
        run_txn(0, 16'hF0F0, 1'b0, 1'b0, got, issued);
        check("newaddr_gnt", 64'(got), 64'd2);
        check("newaddr_addr", 64'(issued), 64'h44);

        // Randomized traffic: random request sets, addresses, stalls and drops.
        for (int it = 0; it < 30; it++) begin
            v = NC'($urandom);
            bus.consumer_read_valid = v;
            for (int j = 0; j < NC; j++) bus.consumer_read_address[j] = AB'($urandom);
            if (v == '0) begin
                tick();
                check("rand_idle", 64'(bus.mem_read_valid), 64'd0);
            end else begin
                run_txn(int'($urandom_range(0, 4)), DB'($urandom), 1'($urandom),
                        1'($urandom), got, issued);
                check("rand_gnt", 64'(got), 64'(last_served));
            end
        end

        // Reset during READ_WAITING, then a late memory strobe after release.
        bus.consumer_read_valid      = 4'b0001;
        bus.consumer_read_address[0] = 8'h55;
        tick();
        check("mid_vld", 64'(bus.mem_read_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        bus.consumer_read_valid = '0;
        model_reset();
        tick();
        reset_n            = 1'b1;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs("late_rdy");
        end
        bus.mem_read_ready = 1'b0;

        // After reset consumer 0 wins first again; five completions counted.
        bus.consumer_read_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, DB'($urandom), 1'b0, 1'b0, got, issued);
            check("post_rst_order", 64'(got), 64'(order[i]));
        end
        bus.consumer_read_valid = '0;
`ifdef PROGRAM_MEM_CTRL_PERF_EN
        check("count_five", 64'(read_count), 64'd5);
        #2 reset_n = 1'b0;
        #1 check("count_rst", 64'(read_count), 64'd0);
        tick();
        reset_n = 1'b1;
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
